// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
//
// Forwarding and load-use hazard controller for the 5-stage core. It keeps a
// shadow copy of the destination-register metadata of the instructions in
// EX, MEM and WB. From that copy it derives the operand-mux selects for the
// instruction in EX, and the load-use stall for the instruction in ID.
//
// Select encoding (operand muxes in EX):
//   2'b10  EX/MEM result
//   2'b01  MEM/WB writeback value
//   2'b00  register-file value
//
// Signalling: id_valid qualifies the ID fields in the same cycle. There is no
// ready. The consumer is throttled only through 'stall'. While stall=1 the
// source must present the same ID instruction again on the next cycle,
// because the EX slot it would have taken becomes a bubble. 'hold' freezes
// every record. A 'flush' seen during hold is dropped, so its source must
// assert it again.
//
// Ports:
//   clk           core clock, rising-edge
//   arst_n        asynchronous active-low reset
//   id_valid      instruction present in ID
//   id_rs1/rs2    ID source registers
//   id_rd         ID destination register
//   id_reg_write  ID instruction writes rd
//   id_mem_read   ID instruction is a load
//   flush         kill the ID instruction (EX becomes a bubble)
//   hold          global freeze
//   select_a/b    operand-A/B mux selects for the EX instruction
//   stall         load-use stall request to PC / IF-ID
//   stall_count   saturating count of counted stall cycles
// -----------------------------------------------------------------------------
module forwarding_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  hold,
    output logic [1:0]            select_a,
    output logic [1:0]            select_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_RF    = 2'b00;

    // EX record
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wr;
    logic                  ex_ld;

    // MEM record
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_wr;
    logic                  mem_ld;

    // WB record
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_wr;

    // A record only produces a value that someone can use if it writes a
    // register other than x0.
    logic ex_writer;
    logic mem_writer;
    logic wb_writer;

    assign ex_writer  = ex_valid  & ex_wr  & (ex_rd  != '0);
    assign mem_writer = mem_valid & mem_wr & (mem_rd != '0);
    assign wb_writer  = wb_valid  & wb_wr  & (wb_rd  != '0);

    // A load in MEM has no data yet. It is excluded from the EX/MEM path, so
    // the source falls through to MEM/WB or the register file.
    logic mem_fwd_ok;
    assign mem_fwd_ok = mem_writer & ~mem_ld;

    // ------------------------------------------------------------------
    // Operand selects (combinational from the registered records)
    // ------------------------------------------------------------------
    always_comb begin
        select_a = SEL_RF;
        select_b = SEL_RF;
        if (ex_valid) begin
            if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
                select_a = SEL_EXMEM;
            end else if (wb_writer && (wb_rd == ex_rs1)) begin
                select_a = SEL_MEMWB;
            end

            if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
                select_b = SEL_EXMEM;
            end else if (wb_writer && (wb_rd == ex_rs2)) begin
                select_b = SEL_MEMWB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load-use stall. Both source fields are compared whatever the
    // consumer's format is, so some stalls are unnecessary but safe. One
    // bubble is enough: the consumer then meets the load in WB.
    // ------------------------------------------------------------------
    always_comb begin
        stall = id_valid & ex_writer & ex_ld &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end

    // ------------------------------------------------------------------
    // Shadow pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid  <= 1'b0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_wr    <= 1'b0;
            mem_ld    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_wr     <= 1'b0;
        end else if (!hold) begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_wr     <= mem_wr;

            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_wr    <= ex_wr;
            mem_ld    <= ex_ld;

            // The fields are copied even for a bubble. Only valid matters.
            ex_valid  <= id_valid & ~stall & ~flush;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;
            ex_wr     <= id_reg_write;
            ex_ld     <= id_mem_read;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter. Stall cycles spent under hold are not
    // counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_count <= '0;
        end else if (stall && !hold && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Pipeline forwarding and load-use hazard controller for the 5-stage core. It tracks destination-register metadata of in-flight instructions in its own shadow pipeline (ID/EX, EX/MEM, MEM/WB). It drives the 2-bit select codes of the two EX-stage operand muxes: 2'b10 selects the EX/MEM result, 2'b01 the MEM/WB writeback value, 2'b00 the register-file value. It also raises the load-use stall toward the IF/ID stages and keeps a saturating stall counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- arst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  instruction present in ID
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  kill ID instruction (taken branch resolved in EX)
- hold  in  1  global freeze (memory wait)
- select_a  out  2  operand-A mux select for EX instruction
- select_b  out  2  operand-B mux select for EX instruction
- stall  out  1  load-use stall request to PC/IF-ID
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Records: EX = {valid, rs1, rs2, rd, wr, ld}; MEM = {valid, rd, wr, ld}; WB = {valid, rd, wr}.
- The advance rule applies per clock, in priority order:
  - hold=1: all records keep their values; flush is ignored and must be re-asserted by its source; stall_count is not incremented.
  - Otherwise, WB <= MEM and MEM <= EX.
  - EX gets the ID fields with valid = id_valid & ~stall & ~flush. When stall=1 or flush=1, EX becomes a bubble (valid=0).
- A record is a writer when valid & wr & (rd != 0). Register x0 is never forwarded.
- select_a is combinational from the records:
  - 2'b10 if MEM is a writer, MEM.ld=0, and MEM.rd == EX.rs1.
  - Else 2'b01 if WB is a writer and WB.rd == EX.rs1.
  - Else 2'b00.
  - EX/MEM has priority over MEM/WB when both match.
- select_b uses the same rules with EX.rs2.
- If EX.valid=0, both selects are 2'b00.
- A load in MEM is never forwarded from EX/MEM, because its data is not ready. It falls through to the WB or register-file source.
- stall = id_valid & EX is a writer & EX.ld & (EX.rd == id_rs1 | EX.rd == id_rs2).
  - A single bubble is inserted. The consumer then reaches EX with the load in WB and gets 2'b01.
- The stall check ignores id_reg_write and id_mem_read of the consumer. Both rs fields are compared regardless of instruction format (conservative stall).
- stall_count increments when stall=1 & hold=0 and saturates at all-ones.

## Timing
- Reset (arst_n=0, asynchronous): all record valids and fields are 0, select_a = select_b = 2'b00, stall=0, stall_count=0. The first edge after deassertion behaves as a normal advance.
- Reset mid-operation discards all in-flight records immediately; outputs go to reset values in the same cycle, without waiting for a clock.
- An ID instruction becomes EX at the next edge. Its selects are valid in that cycle, combinationally from the registered records.
- stall is a same-cycle combinational response to ID inputs. It is asserted for exactly one cycle per load-use pair, because EX becomes a bubble on the next edge.
- flush and stall together: EX gets a bubble; stall_count still increments.
- hold and stall together: stall stays asserted, records are frozen, and the counter does not count.

## Test plan
- Reset: drive arst_n=0 mid-stream with valid records -> selects=00, stall=0, stall_count=0 without a clock edge.
- ALU chain: add x5 followed by sub x6,x5,x5 -> in sub's EX cycle select_a=10 and select_b=10. Add nop in between -> select_a=01 and select_b=01.
- Double hazard: add x3 ; add x3 ; add x7,x3,x0 -> select_a=10 (youngest writer wins), select_b=00.
- Load-use: lw x4 ; add x8,x4,x1 -> stall=1 for one cycle and stall_count increments by 1. The add then sees select_a=01.
- x0 and invalid records: add x0 ; add x9,x0,x0 -> selects=00. flush on the producer's ID cycle -> no forward from the killed instruction.
- Hold and saturation: hold=1 for 3 cycles during a load-use -> records frozen, stall held at 1, count unchanged. With CNT_W=2, 5 stalls -> stall_count=3.
